// File: rtl/fpu_seq_ctrl_pkg.sv
// Shared definitions for the FPU test-vector sequencer: state encoding,
// op/format codes and the operand/result format mask.
package fpu_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_WAIT,
        S_CAPTURE,
        S_HOLD,
        S_DONE
    } seq_state_t;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;

    localparam logic [1:0] FMT_FP32 = 2'b00;
    localparam logic [1:0] FMT_FP16 = 2'b01;
    localparam logic [1:0] FMT_E4M3 = 2'b10;
    localparam logic [1:0] FMT_E5M2 = 2'b11;

    // Narrow formats live in the low bits of the 32-bit lane; upper bits are cleared.
    function automatic logic [31:0] fmt_mask(input logic [1:0] fmt, input logic [31:0] x);
        logic [31:0] m;
        case (fmt)
            FMT_FP16:           m = {16'h0000, x[15:0]};
            FMT_E4M3, FMT_E5M2: m = {24'h000000, x[7:0]};
            default:            m = x;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/fpu_seq_ctrl_if.sv
// RAM read port and shared FPU operand/result lanes driven by fpu_seq_ctrl.
interface fpu_seq_ctrl_if #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 5
);
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_q;
    logic [31:0]           fpu_a;
    logic [31:0]           fpu_b;
    logic                  fpu_addsub;
    logic                  fpu_sel_mul;
    logic [31:0]           fpu_c;

    modport master (
        output ram_addr, fpu_a, fpu_b, fpu_addsub, fpu_sel_mul,
        input  ram_q, fpu_c
    );

    modport slave (
        input  ram_addr, fpu_a, fpu_b, fpu_addsub, fpu_sel_mul,
        output ram_q, fpu_c
    );
endinterface

// File: rtl/fpu_seq_ctrl_fmt_mask.sv
// Combinational float-format mask for one 32-bit lane.
module fpu_fmt_mask
    import fpu_pkg::*;
(
    input  logic [1:0]  fmt,
    input  logic [31:0] din,
    output logic [31:0] dout
);
    always_comb begin
        dout = fmt_mask(fmt, din);
    end
endmodule

// File: rtl/fpu_seq_ctrl.sv
// Steps one shared FPU through a 64-bit test-vector RAM and captures results.
// FPU_SEQ_AUTORUN_EN: when defined, vectors run back-to-back without `next`.
module fpu_seq_ctrl
    import fpu_pkg::*;
#(
    parameter int DATA_WIDTH  = 64,
    parameter int ADDR_WIDTH  = 5,
    parameter int NUM_VECTORS = 2**ADDR_WIDTH,
    parameter int FPU_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  next,
    input  logic [1:0]            op,
    input  logic [1:0]            fmt,
    fpu_seq_ctrl_if.master        bus,
    output logic [31:0]           res_a,
    output logic [31:0]           res_b,
    output logic [31:0]           res_c,
    output logic                  res_valid,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] vec_idx
);
    localparam int CNT_W = (FPU_LATENCY > 1) ? $clog2(FPU_LATENCY) : 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_VECTORS - 1);

    seq_state_t       state;
    logic [CNT_W-1:0] wait_cnt;
    logic             start_q;
    logic [1:0]       op_s, fmt_s;
    logic [1:0]       op_l, fmt_l;
    logic             next_q, next_rise;
    logic [31:0]      mask_a, mask_b, mask_c;

    fpu_fmt_mask u_mask_a (.fmt(fmt_l), .din(bus.ram_q[DATA_WIDTH-1 -: 32]), .dout(mask_a));
    fpu_fmt_mask u_mask_b (.fmt(fmt_l), .din(bus.ram_q[31:0]),               .dout(mask_b));
    fpu_fmt_mask u_mask_c (.fmt(fmt_l), .din(bus.fpu_c),                     .dout(mask_c));

    // start/op/fmt and the next edge are registered first, so every control
    // decision is taken one edge after the input was sampled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= S_IDLE;
            wait_cnt        <= '0;
            start_q         <= 1'b0;
            op_s            <= '0;
            fmt_s           <= '0;
            op_l            <= '0;
            fmt_l           <= '0;
            next_q          <= 1'b0;
            next_rise       <= 1'b0;
            bus.ram_addr    <= '0;
            bus.fpu_a       <= '0;
            bus.fpu_b       <= '0;
            bus.fpu_addsub  <= 1'b1;
            bus.fpu_sel_mul <= 1'b0;
            res_a           <= '0;
            res_b           <= '0;
            res_c           <= '0;
            res_valid       <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            vec_idx         <= '0;
        end else begin
            start_q   <= start;
            op_s      <= op;
            fmt_s     <= fmt;
            next_q    <= next;
            next_rise <= next & ~next_q;
            res_valid <= 1'b0;

            case (state)
                S_IDLE, S_DONE: begin
                    if (start_q) begin
                        bus.ram_addr <= '0;
                        op_l         <= op_s;
                        fmt_l        <= fmt_s;
                        busy         <= 1'b1;
                        done         <= 1'b0;
                        state        <= S_FETCH;
                    end
                end
                S_FETCH: state <= S_LOAD;
                S_LOAD: begin
                    bus.fpu_a       <= mask_a;
                    bus.fpu_b       <= mask_b;
                    bus.fpu_addsub  <= (op_l != OP_SUB);
                    bus.fpu_sel_mul <= (op_l == OP_MUL);
                    wait_cnt        <= CNT_W'(FPU_LATENCY - 1);
                    state           <= S_WAIT;
                end
                S_WAIT: begin
                    if (wait_cnt == '0)
                        state <= S_CAPTURE;
                    else
                        wait_cnt <= wait_cnt - 1'b1;
                end
                S_CAPTURE: begin
                    res_a     <= bus.fpu_a;
                    res_b     <= bus.fpu_b;
                    res_c     <= mask_c;
                    res_valid <= 1'b1;
                    vec_idx   <= bus.ram_addr;
                    if (bus.ram_addr == LAST_ADDR) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
`ifdef FPU_SEQ_AUTORUN_EN
                        bus.ram_addr <= bus.ram_addr + 1'b1;
                        state        <= S_FETCH;
`else
                        state <= S_HOLD;
`endif
                    end
                end
                S_HOLD: begin
                    if (next_rise) begin
                        bus.ram_addr <= bus.ram_addr + 1'b1;
                        state        <= S_FETCH;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fpu_seq_ctrl.sv
// Scoreboard bench for fpu_seq_ctrl with a RAM model and an integer FPU stub.
module tb_fpu_seq_ctrl;
    import fpu_pkg::*;

    localparam int DW  = 64;
    localparam int AW  = 5;
    localparam int NV  = 4;
    localparam int LAT = 2;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        int          idx;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset, start, next;
    logic [1:0]    op, fmt;
    logic [31:0]   res_a, res_b, res_c;
    logic          res_valid, busy, done;
    logic [AW-1:0] vec_idx;
    logic          force_ones;
    logic [DW-1:0] mem [2**AW];

    logic [1:0]    run_op, run_fmt;
    exp_t          sbq[$];
    exp_t          e_mon;
    int            n_cmp  = 0;
    int            n_fail = 0;
    int            rv_count = 0;

    fpu_seq_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    fpu_seq_ctrl #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_VECTORS(NV), .FPU_LATENCY(LAT)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .next(next), .op(op), .fmt(fmt),
        .bus(bus), .res_a(res_a), .res_b(res_b), .res_c(res_c),
        .res_valid(res_valid), .busy(busy), .done(done), .vec_idx(vec_idx)
    );

    always #5 clk = ~clk;

    initial bus.ram_q = '0;
    always @(posedge clk) bus.ram_q <= mem[bus.ram_addr];

    assign bus.fpu_c = force_ones ? 32'hFFFF_FFFF :
                       bus.fpu_sel_mul ? bus.fpu_b :
                       bus.fpu_addsub  ? bus.fpu_a + bus.fpu_b : bus.fpu_a - bus.fpu_b;

    function automatic logic [31:0] mdl_mask(input logic [1:0] f, input logic [31:0] x);
        if (f == 2'd0) return x;
        if (f == 2'd1) return x % 32'h0001_0000;
        return x % 32'h0000_0100;
    endfunction

    // Op semantics of the stub: mul returns B, sub returns A-B, add/reserved A+B.
    function automatic logic [31:0] mdl_fpu(input logic [31:0] a, input logic [31:0] b, input logic [1:0] o);
        if (o == 2'd2) return b;
        if (o == 2'd1) return a - b;
        return a + b;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic exp_push(input int idx);
        exp_t e;
        logic [63:0] w;
        w     = mem[idx];
        e.a   = mdl_mask(run_fmt, w[63:32]);
        e.b   = mdl_mask(run_fmt, w[31:0]);
        e.c   = force_ones ? mdl_mask(run_fmt, 32'hFFFF_FFFF) : mdl_mask(run_fmt, mdl_fpu(e.a, e.b, run_op));
        e.idx = idx;
        sbq.push_back(e);
    endtask

    always @(negedge clk) begin
        if (res_valid) begin
            rv_count++;
            if (sbq.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_res_valid: got res_valid=1 vec_idx=%0d expected no result", vec_idx);
            end else begin
                e_mon = sbq.pop_front();
                chk("res_a", res_a, e_mon.a);
                chk("res_b", res_b, e_mon.b);
                chk("res_c", res_c, e_mon.c);
                chk("vec_idx", 32'(vec_idx), 32'(e_mon.idx));
            end
        end
    end

    // One start or next request; counts res_valid pulses and first-pulse latency in edges.
    task automatic issue(input bit is_start, input int hold, input int exp_pulses,
                         input int idx, input bit disturb);
        int pulses, first;
        pulses = 0;
        first  = -1;
        @(negedge clk);
        if (exp_pulses > 0) exp_push(idx);
        if (is_start) begin
            op    = run_op;
            fmt   = run_fmt;
            start = 1'b1;
        end else begin
            next = 1'b1;
        end
        for (int e = 0; e < LAT + 11; e++) begin
            @(posedge clk);
            #1;
            if (res_valid) begin
                pulses++;
                if (first < 0) first = e;
            end
            if (e == 0) start = 1'b0;
            if (e >= hold - 1) next = 1'b0;
            if (disturb && e == 3) begin
                start = 1'b1;
                op    = ~op;
                fmt   = ~fmt;
            end
            if (disturb && e == 4) start = 1'b0;
        end
        chk("pulse_count", 32'(pulses), 32'(exp_pulses));
        if (exp_pulses > 0) chk("latency", 32'(first), 32'(LAT + 4));
    endtask

    task automatic full_run(input logic [1:0] o, input logic [1:0] f);
        run_op  = o;
        run_fmt = f;
`ifdef FPU_SEQ_AUTORUN_EN
        begin
            int pulses, last;
            pulses = 0;
            last   = 0;
            @(negedge clk);
            for (int i = 0; i < NV; i++) exp_push(i);
            op    = o;
            fmt   = f;
            start = 1'b1;
            for (int e = 0; e < NV * (LAT + 3) + LAT + 12; e++) begin
                @(posedge clk);
                #1;
                if (e == 0) start = 1'b0;
                if (res_valid) begin
                    if (pulses == 0) chk("first_latency", 32'(e), 32'(LAT + 4));
                    else             chk("spacing", 32'(e - last), 32'(LAT + 3));
                    pulses++;
                    last = e;
                end
            end
            chk("auto_pulses", 32'(pulses), 32'(NV));
        end
`else
        issue(1'b1, 1, 1, 0, 1'b0);
        chk("fpu_a", bus.fpu_a, mdl_mask(f, mem[0][63:32]));
        chk("fpu_b", bus.fpu_b, mdl_mask(f, mem[0][31:0]));
        chk("fpu_sel_mul", 32'(bus.fpu_sel_mul), 32'(o == 2'd2));
        chk("fpu_addsub", 32'(bus.fpu_addsub), 32'(o != 2'd1));
        for (int i = 1; i < NV; i++) issue(1'b0, 1, 1, i, 1'b0);
`endif
        chk("done", 32'(done), 32'd1);
        chk("busy", 32'(busy), 32'd0);
        chk("final_vec_idx", 32'(vec_idx), 32'(NV - 1));
        chk("final_ram_addr", 32'(bus.ram_addr), 32'(NV - 1));
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_ram_addr"}, 32'(bus.ram_addr), 32'd0);
        chk({tag, "_fpu_a"}, bus.fpu_a, 32'd0);
        chk({tag, "_fpu_b"}, bus.fpu_b, 32'd0);
        chk({tag, "_fpu_addsub"}, 32'(bus.fpu_addsub), 32'd1);
        chk({tag, "_fpu_sel_mul"}, 32'(bus.fpu_sel_mul), 32'd0);
        chk({tag, "_res_a"}, res_a, 32'd0);
        chk({tag, "_res_c"}, res_c, 32'd0);
        chk({tag, "_res_valid"}, 32'(res_valid), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_vec_idx"}, 32'(vec_idx), 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0; next = 1'b0; op = '0; fmt = '0; force_ones = 1'b0;
        for (int i = 0; i < 2**AW; i++) mem[i] = {$urandom, $urandom};
        #1;
        chk_reset_state("rst");
        repeat (3) @(negedge clk);
        reset = 1'b0;

        mem[0] = 64'h3F80_0000_4000_0000;
        full_run(OP_MUL, FMT_FP32);

        mem[0] = 64'h1234_5678_9ABC_DEF0;
        force_ones = 1'b1;
        full_run(OP_ADD, FMT_FP16);
        full_run(OP_SUB, FMT_E4M3);
        force_ones = 1'b0;

        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < NV; i++) mem[i] = {$urandom, $urandom};
            full_run(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
        end

`ifndef FPU_SEQ_AUTORUN_EN
        // Held next steps once; start and op/fmt changes mid-run are ignored.
        run_op  = OP_SUB;
        run_fmt = 2'($urandom_range(0, 3));
        issue(1'b1, 1, 1, 0, 1'b0);
        chk("sub_addsub", 32'(bus.fpu_addsub), 32'd0);
        issue(1'b0, 10, 1, 1, 1'b0);
        chk("held_next_addr", 32'(bus.ram_addr), 32'd1);
        issue(1'b0, 1, 1, 2, 1'b1);
        issue(1'b0, 1, 1, 3, 1'b0);
        chk("run_done", 32'(done), 32'd1);
        chk("run_busy", 32'(busy), 32'd0);
        issue(1'b0, 1, 0, 0, 1'b0);
        chk("extra_next_done", 32'(done), 32'd1);
        chk("extra_next_addr", 32'(bus.ram_addr), 32'(NV - 1));

        // Async reset during WAIT of vector 3 aborts with no result.
        run_op  = OP_ADD;
        run_fmt = FMT_FP32;
        issue(1'b1, 1, 1, 0, 1'b0);
        issue(1'b0, 1, 1, 1, 1'b0);
        issue(1'b0, 1, 1, 2, 1'b0);
        @(negedge clk);
        next = 1'b1;
        repeat (4) @(posedge clk);
        #2;
        chk("pre_reset_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        next  = 1'b0;
        #1;
        chk_reset_state("midrun");
        begin
            int rv_before;
            rv_before = rv_count;
            repeat (3) @(negedge clk);
            reset = 1'b0;
            repeat (12) @(negedge clk);
            chk("no_res_after_reset", 32'(rv_count - rv_before), 32'd0);
        end
        issue(1'b1, 1, 1, 0, 1'b0);
        chk("restart_addr", 32'(bus.ram_addr), 32'd0);
`endif

        repeat (4) @(negedge clk);
        chk("scoreboard_empty", 32'(sbq.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/fpu_seq_ctrl.md
# fpu_seq_ctrl

Sequencer that drives one shared floating-point unit (multiplier `fpum` or adder/subtractor `fpua`) from a 64-bit test-vector RAM. It replaces the edge-clocked `ramBlock` stepping with a single-clock state machine. For each vector it:

- fetches the word from the synchronous RAM,
- splits it into operands A and B,
- masks the operands to the selected float format,
- presents them to the FPU with op controls, waits a fixed settle latency, then captures the result for display (`bin32ToHex`) or for a bench.

## Interface

Parameters:
- `DATA_WIDTH`, 64: RAM word width. A = `[63:32]`, B = `[31:0]`.
- `ADDR_WIDTH`, 5: RAM address width.
- `NUM_VECTORS`, 2**ADDR_WIDTH: number of vectors per run; legal range 1..2**ADDR_WIDTH.
- `FPU_LATENCY`, 2: cycles between operand issue and result sampling; minimum 1.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `start`  in  1  synchronous pulse; begins a run.
- `next`  in  1  synchronous step request; rising edge detected internally.
- `op`  in  2  00 add, 01 sub, 10 mul, 11 reserved (treated as add).
- `fmt`  in  2  00 FP32, 01 FP16, 10 E4M3, 11 E5M2.
- `ram_addr`  out  ADDR_WIDTH  RAM read address.
- `ram_q`  in  DATA_WIDTH  RAM data, valid one cycle after `ram_addr`.
- `fpu_a`, `fpu_b`  out  32  masked operands.
- `fpu_addsub`  out  1  1 = add, 0 = subtract (matches `fpua` convention).
- `fpu_sel_mul`  out  1  1 = take multiplier result.
- `fpu_c`  in  32  FPU result.
- `res_a`, `res_b`, `res_c`  out  32  captured operands and masked result.
- `res_valid`  out  1  one-cycle pulse when the `res_*` outputs update.
- `busy`  out  1  high in every state except IDLE and DONE.
- `done`  out  1  high in DONE.
- `vec_idx`  out  ADDR_WIDTH  index of the current or last captured vector.

## Operation

States: IDLE, FETCH, LOAD, WAIT, CAPTURE, HOLD, DONE.

- **IDLE**
  - `start` → `ram_addr` = 0, `op` and `fmt` latched, go to FETCH.
  - `op` and `fmt` are ignored at all other times.
- **FETCH**: one cycle for the RAM read, then LOAD.
- **LOAD**
  - `fpu_a`/`fpu_b` ← masked `ram_q` halves.
  - Drive `fpu_addsub` and `fpu_sel_mul` from the latched `op`.
  - Wait counter ← `FPU_LATENCY`-1; go to WAIT.
- **WAIT**: decrement the counter; at 0 go to CAPTURE.
- **CAPTURE**
  - `res_a`/`res_b` ← `fpu_a`/`fpu_b`; `res_c` ← masked `fpu_c`; pulse `res_valid`; `vec_idx` ← `ram_addr`.
  - If `ram_addr` == `NUM_VECTORS`-1, go to DONE.
  - Otherwise go to HOLD (manual mode; see Configuration for auto-run).
- **HOLD**: on a `next` rising edge, `ram_addr` += 1 and go to FETCH.
- **DONE**: `start` restarts from address 0 with freshly latched `op`/`fmt`.

Format masking, applied to operands and result:
- FP32: no masking.
- FP16: keep `[15:0]`, upper bits zero.
- E4M3 and E5M2: keep `[7:0]`, upper bits zero.

Edge and boundary behaviour:
- A `next` edge is sampled only in HOLD. Edges in any other state are dropped, not queued.
- Holding `next` high steps exactly once.
- `start` while `busy` is ignored.
- `start` and a `next` edge in the same cycle in DONE: `start` wins.
- `ram_addr` never wraps within a run; it stops at `NUM_VECTORS`-1.
- Reset mid-run aborts immediately; no `res_valid` is produced.

Reset values:
- State IDLE.
- `ram_addr`, `vec_idx`, `fpu_*`, `res_*` = 0.
- `fpu_addsub` = 1.
- `res_valid`, `busy`, `done` = 0.
- `next` edge register = 0.

## Timing

- `start` sampled at edge k: FETCH k+1, LOAD k+2, WAIT k+3 .. k+2+`FPU_LATENCY`, CAPTURE at k+3+`FPU_LATENCY`.
- `res_valid` is high in the cycle after the CAPTURE edge, i.e. `FPU_LATENCY`+4 edges after `start`.
- `fpu_*` operands are stable from LOAD through CAPTURE.
- `next` edge in HOLD: the next `res_valid` follows `FPU_LATENCY`+4 edges later.
- Auto-run throughput: one vector per `FPU_LATENCY`+3 cycles.
- All outputs are registered.

## Configuration

`FPU_SEQ_AUTORUN_EN`:
- **Defined**: CAPTURE goes directly to FETCH with `ram_addr`+1. HOLD is unreachable and `next` is ignored.
- **Undefined**: manual stepping through HOLD as described in Operation.

## Structure

- Shared package `fpu_pkg`:
  - state enum;
  - `op` encodings (`OP_ADD`, `OP_SUB`, `OP_MUL`);
  - `fmt` encodings (`FMT_FP32`, `FMT_FP16`, `FMT_E4M3`, `FMT_E5M2`);
  - format mask function.
- One sub-module, `fpu_fmt_mask` (combinational, 32-bit in/out, `fmt` select). Instantiated three times: `fpu_a`, `fpu_b`, `res_c`.

## Test plan

1. Word0 = 0x3F800000_40000000, `op`=10, `fmt`=00, `FPU_LATENCY`=2, `start` at edge 0 → `fpu_a`=0x3F800000, `fpu_b`=0x40000000, `fpu_sel_mul`=1; `res_valid` high only in the cycle after edge 6; `res_c` = `fpu_c` stub (0x40000000).
2. Word0 = 0x12345678_9ABCDEF0, `fmt`=01 → `fpu_a`=0x00005678, `fpu_b`=0x0000DEF0; `fmt`=10 → 0x00000078 / 0x000000F0; `fpu_c` stub 0xFFFFFFFF → `res_c`=0x000000FF.
3. Manual mode, `NUM_VECTORS`=4, `op`=01 → `fpu_addsub`=0.
   - `next` held high 10 cycles gives exactly one step.
   - Four `res_valid` pulses with `vec_idx` 0..3, then `done`=1 and `busy`=0.
   - A fifth `next` changes nothing.
4. `FPU_SEQ_AUTORUN_EN` defined, `NUM_VECTORS`=32 → 32 `res_valid` pulses spaced 5 cycles apart; `done` after `vec_idx`=31; `ram_addr` never returns to 0.
5. `reset` asserted asynchronously during WAIT of vector 3 → all outputs at reset values immediately; no `res_valid`; the next `start` fetches address 0.
6. `start` pulsed while busy and `op` toggled mid-run → ignored; results keep the original op; `start` in DONE restarts from address 0.
